uart_loopback_fifo: RTL

UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

---
 rtl/uart_pkg.sv | 25 ++
 rtl/async_receiver.sv | 58 +++++
 rtl/async_transmitter.sv | 50 +++++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_loopback_fifo.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART loopback echo design.
//   tx_state_t      - encoding of the echo transmit FSM
//   LED_MODE_BYTE   - led_mode value that shows the last received byte
//   LED_MODE_LEVEL  - led_mode value that shows the FIFO fill level
//   CNT_W           - width of the statistics counters
//   sat_to_byte()   - clamps a 16-bit value to 8 bits (saturating at 8'hFF)
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StStart    = 2'd1,
      StWaitBusy = 2'd2,
      StWaitDone = 2'd3
   } tx_state_t;

   localparam logic LED_MODE_BYTE  = 1'b0;
   localparam logic LED_MODE_LEVEL = 1'b1;

   localparam int unsigned CNT_W = 16;

   function automatic logic [7:0] sat_to_byte(input logic [15:0] value);
      return (value > 16'd255) ? 8'hFF : value[7:0];
   endfunction

endpackage

// File: rtl/async_receiver.sv
// async_receiver: 8N1 serial receiver, no reset (line state self-recovers).
//   clk            : system clock
//   RxD            : serial input, idle high
//   RxD_data_ready : one-cycle pulse when a byte with a valid stop bit has arrived
//   RxD_data       : received byte, valid while RxD_data_ready is high
module async_receiver #(
   parameter int unsigned ClkFrequency = 12_000_000,
   parameter int unsigned Baud         = 115_200
) (
   input  logic       clk,
   input  logic       RxD,
   output logic       RxD_data_ready,
   output logic [7:0] RxD_data
);

   localparam int unsigned BIT_DIV = ClkFrequency / Baud;
   localparam int unsigned DIV_W   = $clog2(BIT_DIV) + 1;

   // Synchroniser holds the inverted line so the all-zero power-up state reads as idle.
   logic [1:0]       r_rx_low;
   logic             r_busy;
   logic [DIV_W-1:0] r_cnt;
   logic [3:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_ready;

   always_ff @(posedge clk) begin
      r_rx_low <= {r_rx_low[0], ~RxD};
      r_ready  <= 1'b0;
      if (!r_busy) begin
         if (r_rx_low[1]) begin
            // First sample lands near the middle of the start bit.
            r_busy <= 1'b1;
            r_cnt  <= DIV_W'(BIT_DIV / 2 - 1);
            r_bit  <= 4'd0;
         end
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - DIV_W'(1);
      end else begin
         r_cnt <= DIV_W'(BIT_DIV - 1);
         r_bit <= r_bit + 4'd1;
         if (r_bit == 4'd0) begin
            if (!r_rx_low[1]) begin
               r_busy <= 1'b0;  // glitch, not a real start bit
            end
         end else if (r_bit == 4'd9) begin
            r_busy  <= 1'b0;
            r_ready <= ~r_rx_low[1];
         end else begin
            r_shift <= {~r_rx_low[1], r_shift[7:1]};
         end
      end
   end

   assign RxD_data_ready = r_ready;
   assign RxD_data       = r_shift;

endmodule

// File: rtl/async_transmitter.sv
// async_transmitter: 8N1 serial transmitter, no reset (a frame in flight always completes).
//   clk       : system clock
//   TxD_start : start request, sampled only while not busy
//   TxD_data  : byte to send, captured with TxD_start
//   TxD       : serial output, idle high
//   TxD_busy  : high from the cycle after the start request until the stop bit ends
module async_transmitter #(
   parameter int unsigned ClkFrequency = 12_000_000,
   parameter int unsigned Baud         = 115_200
) (
   input  logic       clk,
   input  logic       TxD_start,
   input  logic [7:0] TxD_data,
   output logic       TxD,
   output logic       TxD_busy
);

   localparam int unsigned BIT_DIV = ClkFrequency / Baud;
   localparam int unsigned DIV_W   = $clog2(BIT_DIV) + 1;

   logic             r_busy;
   logic [9:0]       r_shift;
   logic [DIV_W-1:0] r_cnt;
   logic [3:0]       r_bit;

   always_ff @(posedge clk) begin
      if (!r_busy) begin
         if (TxD_start) begin
            r_busy  <= 1'b1;
            r_shift <= {1'b1, TxD_data, 1'b0};
            r_cnt   <= DIV_W'(BIT_DIV - 1);
            r_bit   <= 4'd0;
         end
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - DIV_W'(1);
      end else begin
         r_cnt <= DIV_W'(BIT_DIV - 1);
         if (r_bit == 4'd9) begin
            r_busy <= 1'b0;
         end else begin
            r_shift <= {1'b1, r_shift[9:1]};
            r_bit   <= r_bit + 4'd1;
         end
      end
   end

   assign TxD      = r_busy ? r_shift[0] : 1'b1;
   assign TxD_busy = r_busy;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping the same cycle)
//   pop          : read request; advances past the head entry (ignored when empty)
//   dout         : head entry, valid whenever empty is low
//   full, empty  : status flags
//   level        : number of stored entries, 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty = (r_level == '0);
   assign full  = (r_level == (AW + 1)'(DEPTH));
   assign level = r_level;
   assign dout  = r_mem[r_rd_ptr];

   // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW + 1)'(1);
            2'b01:   r_level <= r_level - (AW + 1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage is not reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/uart_loopback_fifo.sv
// uart_loopback_fifo: echoes every byte received on rxd back out on txd through a FIFO.
//   clk_12mhz  : system clock
//   reset_n    : asynchronous active-low reset
//   rxd        : serial receive line, idle high
//   led_mode   : 0 = last received byte on led, 1 = FIFO fill level on led
//   txd        : serial transmit line, idle high
//   led        : display register
//   overflow   : sticky, set when a received byte is dropped on a full FIFO
//   rx_count   : received-byte counter, saturating
//   drop_count : dropped-byte counter, saturating
// Build option: define LOOPBACK_STATS_EN to build the two counters; otherwise they read 0.
module uart_loopback_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 12_000_000,
   parameter int unsigned BAUD          = 115_200,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic        clk_12mhz,
   input  logic        reset_n,
   input  logic        rxd,
   input  logic        led_mode,
   output logic        txd,
   output logic [7:0]  led,
   output logic        overflow,
   output logic [15:0] rx_count,
   output logic [15:0] drop_count
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             w_rx_ready;
   logic [7:0]       w_rx_data;
   logic             w_txd_busy;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [7:0]       w_fifo_dout;
   logic [LVL_W-1:0] w_level;

   tx_state_t        r_state;
   logic             r_tx_start;
   logic [7:0]       r_tx_data;
   logic [7:0]       r_led;
   logic [7:0]       r_last_byte;
   logic             r_overflow;

   async_receiver #(
      .ClkFrequency (CLK_FREQUENCY),
      .Baud         (BAUD)
   ) u_rx (
      .clk            (clk_12mhz),
      .RxD            (rxd),
      .RxD_data_ready (w_rx_ready),
      .RxD_data       (w_rx_data)
   );

   async_transmitter #(
      .ClkFrequency (CLK_FREQUENCY),
      .Baud         (BAUD)
   ) u_tx (
      .clk       (clk_12mhz),
      .TxD_start (r_tx_start),
      .TxD_data  (r_tx_data),
      .TxD       (txd),
      .TxD_busy  (w_txd_busy)
   );

   // The pop happens on the IDLE->START edge; the popped byte is registered onto TxD_data
   // together with the one-cycle TxD_start pulse.
   assign w_pop  = (r_state == StIdle) && !w_empty && !w_txd_busy;
   assign w_push = w_rx_ready && (!w_full || w_pop);
   assign w_drop = w_rx_ready && w_full && !w_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_12mhz),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .din     (w_rx_data),
      .dout    (w_fifo_dout),
      .full    (w_full),
      .empty   (w_empty),
      .level   (w_level)
   );

   // Transmit FSM. After a reset during a frame the transmitter keeps running, so IDLE
   // waits for busy to drop before issuing another start.
   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
      end else begin
         r_tx_start <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_pop) begin
                  r_state    <= StStart;
                  r_tx_start <= 1'b1;
                  r_tx_data  <= w_fifo_dout;
               end
            end
            StStart: begin
               r_state <= StWaitBusy;
            end
            StWaitBusy: begin
               if (w_txd_busy) begin
                  r_state <= StWaitDone;
               end
            end
            StWaitDone: begin
               if (!w_txd_busy) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // r_last_byte tracks every received byte regardless of mode, so switching back to byte
   // mode shows data that arrived while the level was displayed.
   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_led       <= 8'h00;
         r_last_byte <= 8'h00;
         r_overflow  <= 1'b0;
      end else begin
         if (w_rx_ready) begin
            r_last_byte <= w_rx_data;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         case (led_mode)
            LED_MODE_BYTE:  r_led <= w_rx_ready ? w_rx_data : r_last_byte;
            LED_MODE_LEVEL: r_led <= sat_to_byte(16'(w_level));
         endcase
      end
   end

   assign led      = r_led;
   assign overflow = r_overflow;

`ifdef LOOPBACK_STATS_EN
   logic [CNT_W-1:0] r_rx_count;
   logic [CNT_W-1:0] r_drop_count;

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_count   <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_rx_ready && (r_rx_count != '1)) begin
            r_rx_count <= r_rx_count + CNT_W'(1);
         end
         if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + CNT_W'(1);
         end
      end
   end

   assign rx_count   = r_rx_count;
   assign drop_count = r_drop_count;
`else
   assign rx_count   = 16'h0000;
   assign drop_count = 16'h0000;
`endif

endmodule
